// File: rtl/coin_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_if
// Description : Valid/ready hand-off of classified coins to the vending core.
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_if;
  logic       coin_valid;
  logic       coin_ready;
  logic [1:0] coin_code;
  logic [4:0] coin_cents;

  modport master (
    output coin_valid,
    output coin_code,
    output coin_cents,
    input  coin_ready
  );

  modport slave (
    input  coin_valid,
    input  coin_code,
    input  coin_cents,
    output coin_ready
  );
endinterface
`default_nettype wire

// File: rtl/coin_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : coin_deserializer
// Description : Serial coin-word capture, value-window classification and
//               accepted-coin FIFO feeding the vending core.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_deserializer #(
  parameter int WORD_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int PENNY_LO   = 745,
  parameter int NICKEL_LO  = 830,
  parameter int DIME_LO    = 700,
  parameter int QUARTER_LO = 950,
  parameter int WIN        = 10
) (
  input  wire logic                        clk,
  input  wire logic                        reset,
  input  wire logic                        serialIn,
  input  wire logic                        enable,
  coin_if.master                           coin,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             reject,
  output logic                             overflow,
  output logic                             frame_err
);
  localparam int c_CNT_W = $clog2(WORD_W);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WORD_W - 1);
  localparam logic [c_LVL_W-1:0] c_FULL     = c_LVL_W'(FIFO_DEPTH);
  // Windows held one bit wider so LO+WIN-1 can never wrap.
  localparam logic [WORD_W:0] c_PENNY_LO   = (WORD_W+1)'(PENNY_LO);
  localparam logic [WORD_W:0] c_PENNY_HI   = (WORD_W+1)'(PENNY_LO + WIN - 1);
  localparam logic [WORD_W:0] c_NICKEL_LO  = (WORD_W+1)'(NICKEL_LO);
  localparam logic [WORD_W:0] c_NICKEL_HI  = (WORD_W+1)'(NICKEL_LO + WIN - 1);
  localparam logic [WORD_W:0] c_DIME_LO    = (WORD_W+1)'(DIME_LO);
  localparam logic [WORD_W:0] c_DIME_HI    = (WORD_W+1)'(DIME_LO + WIN - 1);
  localparam logic [WORD_W:0] c_QUARTER_LO = (WORD_W+1)'(QUARTER_LO);
  localparam logic [WORD_W:0] c_QUARTER_HI = (WORD_W+1)'(QUARTER_LO + WIN - 1);

  logic [WORD_W-1:0]  r_shreg;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [1:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;

  logic [WORD_W-1:0]  w_word;
  logic [WORD_W:0]    w_word_x;
  logic               w_complete;
  logic               w_hit;
  logic [1:0]         w_code;
  logic               w_pop;
  logic               w_push;

  assign w_word     = {r_shreg[WORD_W-2:0], serialIn};
  assign w_word_x   = {1'b0, w_word};
  assign w_complete = enable && (r_bit_cnt == c_LAST_BIT);

  always_comb begin
    w_hit  = 1'b0;
    w_code = 2'd0;
    if (w_word_x >= c_PENNY_LO && w_word_x <= c_PENNY_HI) begin
      w_hit  = 1'b1;
      w_code = 2'd0;
    end else if (w_word_x >= c_NICKEL_LO && w_word_x <= c_NICKEL_HI) begin
      w_hit  = 1'b1;
      w_code = 2'd1;
    end else if (w_word_x >= c_DIME_LO && w_word_x <= c_DIME_HI) begin
      w_hit  = 1'b1;
      w_code = 2'd2;
    end else if (w_word_x >= c_QUARTER_LO && w_word_x <= c_QUARTER_HI) begin
      w_hit  = 1'b1;
      w_code = 2'd3;
    end
  end

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_pop  = (r_level != '0) && coin.coin_ready;
  assign w_push = w_complete && w_hit && ((r_level < c_FULL) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      reject    <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      reject    <= w_complete && !w_hit;
      overflow  <= w_complete && w_hit && !w_push;
      frame_err <= !enable && (r_bit_cnt != '0);

      if (enable) begin
        r_shreg   <= w_word;
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
      end else begin
        r_bit_cnt <= '0;
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_code;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  assign fifo_level      = r_level;
  assign coin.coin_valid = (r_level != '0);
  assign coin.coin_code  = r_mem[r_rd_ptr];

  always_comb begin
    coin.coin_cents = 5'd1;
    case (coin.coin_code)
      2'd0: coin.coin_cents = 5'd1;
      2'd1: coin.coin_cents = 5'd5;
      2'd2: coin.coin_cents = 5'd10;
      2'd3: coin.coin_cents = 5'd25;
      default: coin.coin_cents = 5'd1;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_coin_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_deserializer
// Description : Directed bench for coin_deserializer with expected-coin queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_deserializer;
  logic       clk = 1'b0;
  logic       reset;
  logic       serialIn;
  logic       enable;
  logic [2:0] fifo_level;
  logic       reject, overflow, frame_err;

  int total = 0;
  int bad   = 0;
  int rej_seen = 0, ovf_seen = 0, fe_seen = 0;
  logic [1:0] expq [$];

  coin_if cif ();

  coin_deserializer dut (
    .clk        (clk),
    .reset      (reset),
    .serialIn   (serialIn),
    .enable     (enable),
    .coin       (cif.master),
    .fifo_level (fifo_level),
    .reject     (reject),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] cents_of(input logic [1:0] code);
    case (code)
      2'd0: return 5'd1;
      2'd1: return 5'd5;
      2'd2: return 5'd10;
      default: return 5'd25;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // MSB first; optionally raise coin_ready only for the completing cycle.
  task automatic send_word(input logic [9:0] w, input bit rdy_last);
    for (int i = 9; i >= 0; i--) begin
      enable   = 1'b1;
      serialIn = w[i];
      if (i == 0 && rdy_last) cif.coin_ready = 1'b1;
      cyc();
    end
    if (rdy_last) cif.coin_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    enable         = 1'b0;
    cif.coin_ready = 1'b1;
    repeat (n) cyc();
    cif.coin_ready = 1'b0;
  endtask

  // Scoreboard side: every accepted hand-off must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (reject)    rej_seen++;
      if (overflow)  ovf_seen++;
      if (frame_err) fe_seen++;
      if (cif.coin_valid && cif.coin_ready) begin
        logic [1:0] e;
        chk("pop_expected", (expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("pop_code", cif.coin_code, e);
          chk("pop_cents", cif.coin_cents, cents_of(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    serialIn       = 1'b0;
    cif.coin_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", cif.coin_valid, 0);
    chk("rst_code", cif.coin_code, 0);
    chk("rst_cents", cif.coin_cents, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_pulses", {reject, overflow, frame_err}, 0);
    reset = 1'b0;
    cyc();

    // single penny
    expq.push_back(2'd0);
    send_word(10'd750, 0);
    enable = 1'b0;
    chk("t1_valid", cif.coin_valid, 1);
    chk("t1_code", cif.coin_code, 0);
    chk("t1_cents", cif.coin_cents, 1);
    chk("t1_level", fifo_level, 1);
    drain(1);
    chk("t1_level_drained", fifo_level, 0);

    // back-to-back quarter, nickel, dime
    expq.push_back(2'd3); send_word(10'd955, 0);
    expq.push_back(2'd1); send_word(10'd835, 0);
    expq.push_back(2'd2); send_word(10'd705, 0);
    enable = 1'b0;
    chk("t2_level", fifo_level, 3);
    chk("t2_head", cif.coin_code, 3);
    drain(3);
    chk("t2_level_drained", fifo_level, 0);

    // window edges
    send_word(10'd744, 0);
    chk("t3_rej744", reject, 1);
    chk("t3_lvl744", fifo_level, 0);
    send_word(10'd760, 0);
    chk("t3_rej760", reject, 1);
    send_word(10'd1023, 0);
    chk("t3_rej1023", reject, 1);
    chk("t3_lvl1023", fifo_level, 0);
    expq.push_back(2'd0); send_word(10'd745, 0);
    chk("t3_acc745", {reject, fifo_level}, {1'b0, 3'd1});
    expq.push_back(2'd0); send_word(10'd754, 0);
    chk("t3_acc754", {reject, fifo_level}, {1'b0, 3'd2});
    send_word(10'd755, 0);
    chk("t3_rej755", {reject, fifo_level}, {1'b1, 3'd2});
    enable = 1'b0;
    cyc();
    chk("t3_rej_cleared", reject, 0);
    drain(2);
    chk("t3_rej_count", rej_seen, 4);
    chk("t3_level_drained", fifo_level, 0);

    // overflow with full FIFO
    for (int k = 0; k < 4; k++) begin
      expq.push_back(2'd3);
      send_word(10'd950, 0);
    end
    chk("t4_full", fifo_level, 4);
    chk("t4_no_ovf_yet", overflow, 0);
    send_word(10'd950, 0);
    chk("t4_ovf", overflow, 1);
    chk("t4_lvl_ovf", fifo_level, 4);
    expq.push_back(2'd3);
    send_word(10'd950, 1);
    chk("t4_no_ovf_pop", overflow, 0);
    chk("t4_lvl_pop", fifo_level, 4);
    drain(4);
    chk("t4_level_drained", fifo_level, 0);
    chk("t4_ovf_count", ovf_seen, 1);

    // partial word
    for (int i = 0; i < 6; i++) begin
      enable   = 1'b1;
      serialIn = i[0];
      cyc();
    end
    enable = 1'b0;
    cyc();
    chk("t5_frame_err", frame_err, 1);
    chk("t5_level", fifo_level, 0);
    cyc();
    chk("t5_frame_err_clr", frame_err, 0);
    expq.push_back(2'd1);
    send_word(10'd830, 0);
    enable = 1'b0;
    chk("t5_nickel", {cif.coin_valid, cif.coin_code}, {1'b1, 2'd1});
    drain(1);
    chk("t5_fe_count", fe_seen, 1);

    // reset mid-word with coins buffered
    expq.push_back(2'd0); send_word(10'd750, 0);
    expq.push_back(2'd3); send_word(10'd955, 0);
    begin
      logic [9:0] pw;
      pw = 10'd830;
      for (int i = 9; i >= 5; i--) begin
        enable   = 1'b1;
        serialIn = pw[i];
        cyc();
      end
    end
    chk("t6_pre_level", fifo_level, 2);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", cif.coin_valid, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_code", cif.coin_code, 0);
    chk("t6_rst_cents", cif.coin_cents, 1);
    expq.delete();
    enable = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("t6_no_frame_err", frame_err, 0);
    expq.push_back(2'd2);
    send_word(10'd705, 0);
    enable = 1'b0;
    chk("t6_clean", {reject, cif.coin_valid, cif.coin_code, fifo_level}, {1'b0, 1'b1, 2'd2, 3'd1});
    drain(1);
    chk("t6_level_drained", fifo_level, 0);

    chk("end_queue_empty", expq.size(), 0);
    chk("end_fe_count", fe_seen, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
